// File: rtl/rob_order_queue.sv
// In-order reorder buffer: allocates tags at dispatch, captures CDB results,
// forwards completed values and retires the head entry, flushing on a mispredicted branch.
module rob_order_queue #(
  parameter int ROB_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  output logic                 issue_ready,
  input  logic [6:0]           issue_opcode,
  input  logic [4:0]           issue_rd_s,
  output logic [ROB_DEPTH-1:0] issue_rob,
  input  logic                 cdb_valid,
  input  logic [ROB_DEPTH-1:0] cdb_rob,
  input  logic [31:0]          cdb_v,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target_pc,
  input  logic [ROB_DEPTH-1:0] rs1_rob,
  input  logic [ROB_DEPTH-1:0] rs2_rob,
  output logic                 rs1_rob_ready,
  output logic                 rs2_rob_ready,
  output logic [31:0]          rs1_rob_v,
  output logic [31:0]          rs2_rob_v,
  output logic                 commit_valid,
  output logic                 commit_reg_write,
  output logic [4:0]           commit_rd_s,
  output logic [31:0]          commit_rd_v,
  output logic [ROB_DEPTH-1:0] commit_rob,
  output logic                 flush,
  output logic [31:0]          flush_pc
);

  localparam int N = 1 << ROB_DEPTH;
  localparam logic [ROB_DEPTH:0]   FULL_COUNT = {1'b1, {ROB_DEPTH{1'b0}}};
  localparam logic [ROB_DEPTH:0]   CNT_ONE    = (ROB_DEPTH+1)'(1'b1);
  localparam logic [ROB_DEPTH-1:0] PTR_ONE    = ROB_DEPTH'(1'b1);
  localparam logic [6:0]           OP_BRANCH  = 7'b1100011;
  localparam logic [6:0]           OP_STORE   = 7'b0100011;

  logic [N-1:0]         valid_r;
  logic [N-1:0]         done_r;
  logic [N-1:0]         mispred_r;
  logic [6:0]           opcode_r [N];
  logic [4:0]           rd_r     [N];
  logic [31:0]          value_r  [N];
  logic [31:0]          target_r [N];
  logic [ROB_DEPTH-1:0] head_r;
  logic [ROB_DEPTH-1:0] tail_r;
  logic [ROB_DEPTH:0]   count_r;
  logic                 alloc_s;

  // Branches and stores retire without touching the register file; x0 is never written.
  function automatic logic writes_reg(input logic [6:0] opcode, input logic [4:0] rd);
    return (rd != 5'd0) && (opcode != OP_BRANCH) && (opcode != OP_STORE);
  endfunction

  assign issue_ready = (count_r != FULL_COUNT) & ~flush;
  assign issue_rob   = tail_r;
  assign alloc_s     = issue & issue_ready;

  // Head-entry retirement and flush decode; payload outputs stay zero unless retiring.
  always_comb begin
    commit_valid = valid_r[head_r] & done_r[head_r];
    commit_rob   = head_r;
    if (commit_valid) begin
      commit_rd_s      = rd_r[head_r];
      commit_rd_v      = value_r[head_r];
      commit_reg_write = writes_reg(opcode_r[head_r], rd_r[head_r]);
      flush            = mispred_r[head_r];
      flush_pc         = target_r[head_r];
    end else begin
      commit_rd_s      = 5'd0;
      commit_rd_v      = 32'd0;
      commit_reg_write = 1'b0;
      flush            = 1'b0;
      flush_pc         = 32'd0;
    end
  end

  // Operand forwarding of completed entries to dispatch (no same-cycle CDB bypass).
  always_comb begin
    rs1_rob_ready = valid_r[rs1_rob] & done_r[rs1_rob];
    rs2_rob_ready = valid_r[rs2_rob] & done_r[rs2_rob];
    if (rs1_rob_ready) begin
      rs1_rob_v = value_r[rs1_rob];
    end else begin
      rs1_rob_v = 32'd0;
    end
    if (rs2_rob_ready) begin
      rs2_rob_v = value_r[rs2_rob];
    end else begin
      rs2_rob_v = 32'd0;
    end
  end

  // Entry array, pointers and occupancy; a flush wins over same-cycle issue and CDB writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= '0;
      done_r    <= '0;
      mispred_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      for (int i = 0; i < N; i++) begin
        opcode_r[i] <= 7'd0;
        rd_r[i]     <= 5'd0;
        value_r[i]  <= 32'd0;
        target_r[i] <= 32'd0;
      end
    end else if (flush) begin
      valid_r   <= '0;
      done_r    <= '0;
      mispred_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
    end else begin
      if (alloc_s) begin
        valid_r[tail_r]   <= 1'b1;
        done_r[tail_r]    <= 1'b0;
        mispred_r[tail_r] <= 1'b0;
        opcode_r[tail_r]  <= issue_opcode;
        rd_r[tail_r]      <= issue_rd_s;
        tail_r            <= tail_r + PTR_ONE;
      end
      if (cdb_valid && valid_r[cdb_rob]) begin
        done_r[cdb_rob]    <= 1'b1;
        mispred_r[cdb_rob] <= cdb_mispredict;
        value_r[cdb_rob]   <= cdb_v;
        target_r[cdb_rob]  <= cdb_target_pc;
      end
      if (commit_valid) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
      end
      case ({alloc_s, commit_valid})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
